// File: rtl/semi_procesador_param.sv
// rtl/semi_procesador_param.sv - multi-cycle accumulator processor with shift-add multiplier
module semi_procesador_param #(
    parameter int W    = 8,
    parameter int NREG = 4,
    localparam int RA  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [4+RA+W-1:0] instr,
    output logic              instr_ready,
    output logic [W-1:0]      LEDS,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal,
    output logic              busy
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t              state, state_next;
    logic [4+RA+W-1:0]   instr_q;
    logic [W-1:0]        acc;
    logic [W-1:0]        regs [NREG];
    logic [2*W-1:0]      prod;
    logic [W-1:0]        mcand;
    logic [CW-1:0]       cnt;

    logic [3:0]          op;
    logic [RA-1:0]       rd;
    logic [W-1:0]        imm;
    logic [W-1:0]        r_val;
    logic                mul_last;

    logic                acc_wr;
    logic [W-1:0]        res;
    logic                c_res;
    logic [W:0]          wide;
    logic [W:0]          mul_sum;
    logic [2*W-1:0]      prod_step;

    assign op       = instr_q[4+RA+W-1 -: 4];
    assign rd       = instr_q[W +: RA];
    assign imm      = instr_q[W-1:0];
    assign r_val    = regs[rd];
    assign mul_last = (cnt == CW'(W-1));

    assign instr_ready = (state == IDLE) && !rst;
    assign busy        = !instr_ready;
    assign LEDS        = acc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid && instr_ready) state_next = EXEC;
            EXEC:    state_next = (op == OP_MUL) ? MUL : IDLE;
            MUL:     if (mul_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ALU; carry defaults to the current flag so ops that leave C alone need no case.
    always_comb begin
        acc_wr = 1'b0;
        res    = acc;
        c_res  = flag_c;
        wide   = '0;
        case (op)
            OP_LDI: begin acc_wr = 1'b1; res = imm;   end
            OP_LD:  begin acc_wr = 1'b1; res = r_val; end
            OP_ADD: begin
                acc_wr = 1'b1;
                wide   = {1'b0, acc} + {1'b0, r_val};
                res    = wide[W-1:0];
                c_res  = wide[W];
            end
            OP_SUB: begin acc_wr = 1'b1; res = acc - r_val; c_res = (acc < r_val); end
            OP_AND: begin acc_wr = 1'b1; res = acc & r_val; c_res = 1'b0; end
            OP_OR:  begin acc_wr = 1'b1; res = acc | r_val; c_res = 1'b0; end
            OP_XOR: begin acc_wr = 1'b1; res = acc ^ r_val; c_res = 1'b0; end
            OP_SHL: begin acc_wr = 1'b1; res = {acc[W-2:0], 1'b0}; c_res = acc[W-1]; end
            OP_SHR: begin acc_wr = 1'b1; res = {1'b0, acc[W-1:1]}; c_res = acc[0]; end
            default: ;
        endcase
    end

    // Shift-add step: the multiplier sits in the low half of prod and is consumed LSB first.
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        prod_step = {mul_sum, prod[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            illegal <= 1'b0;
            instr_q <= '0;
            prod    <= '0;
            mcand   <= '0;
            cnt     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: if (instr_valid && instr_ready) instr_q <= instr;
                EXEC: begin
                    if (op == OP_MUL) begin
                        prod  <= {{W{1'b0}}, acc};
                        mcand <= r_val;
                        cnt   <= '0;
                    end
                    if (acc_wr) begin
                        acc    <= res;
                        flag_c <= c_res;
                        flag_z <= (res == '0);
                    end
                    if (op == OP_ST) regs[rd] <= acc;
                    if (op > OP_MUL) illegal <= 1'b1;
                end
                MUL: begin
                    prod <= prod_step;
                    cnt  <= cnt + CW'(1);
                    if (mul_last) begin
                        acc    <= prod_step[W-1:0];
                        flag_c <= |prod_step[2*W-1:W];
                        flag_z <= (prod_step[W-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_semi_procesador_param.sv
// tb/tb_semi_procesador_param.sv - directed self-checking bench for semi_procesador_param
module tb_semi_procesador_param;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [13:0] instr;
    logic        instr_ready;
    logic [7:0]  leds;
    logic        flag_z;
    logic        flag_c;
    logic        illegal;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc [3];
    int busy_cnt;

    semi_procesador_param #(.W(8), .NREG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .LEDS        (leds),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!instr_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, instr_ready, 1);
    endtask

    // Called near a negedge; returns at the negedge of the EXEC cycle with valid dropped.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
        wait_ready("issue_ready");
        instr_valid = 1'b1;
        instr       = {op, rd, imm};
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
        issue(op, rd, imm);
        wait_ready("done_ready");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", instr_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_leds", leds, 8'h00);
        check("rst_z", flag_z, 0);
        check("rst_c", flag_c, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        #1 check("post_rst_ready", instr_ready, 1);

        // LDI 0x5A: visible one edge after EXEC
        issue(4'd1, 2'd0, 8'h5A);
        check("ldi_exec_leds_old", leds, 8'h00);
        check("ldi_exec_busy", busy, 1);
        @(negedge clk);
        check("ldi_ready_n2", instr_ready, 1);
        check("ldi_leds", leds, 8'h5A);
        check("ldi_z", flag_z, 0);
        check("ldi_c", flag_c, 0);

        run(4'd3, 2'd0, 8'h00);            // ST r0 = 0x5A
        run(4'd1, 2'd0, 8'hFF);
        run(4'd9, 2'd0, 8'h00);            // SHL -> 0xFE, C=1
        check("shl_leds", leds, 8'hFE);
        check("shl_c", flag_c, 1);

        // Reset during EXEC of LDI 0x77 aborts it
        issue(4'd1, 2'd0, 8'h77);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", instr_ready, 0);
        check("abort_leds", leds, 8'h00);
        check("abort_z", flag_z, 0);
        check("abort_c", flag_c, 0);
        rst = 1'b0;
        #1 check("abort_ready_after", instr_ready, 1);
        run(4'd2, 2'd0, 8'h00);            // LD r0
        check("ld_r0_after_rst", leds, 8'h00);
        check("ld_r0_z", flag_z, 1);

        // ADD / SUB
        run(4'd1, 2'd0, 8'hF0);
        run(4'd3, 2'd1, 8'h00);
        run(4'd1, 2'd0, 8'h20);
        run(4'd4, 2'd1, 8'h00);
        check("add_leds", leds, 8'h10);
        check("add_c", flag_c, 1);
        check("add_z", flag_z, 0);
        run(4'd5, 2'd1, 8'h00);
        check("sub_leds", leds, 8'h20);
        check("sub_c", flag_c, 1);
        run(4'd8, 2'd1, 8'h00);            // XOR 0x20^0xF0
        check("xor_leds", leds, 8'hD0);
        check("xor_c", flag_c, 0);

        // MUL 0x11 * 0x0F: busy for 9 cycles
        run(4'd1, 2'd0, 8'h0F);
        run(4'd3, 2'd2, 8'h00);
        run(4'd1, 2'd0, 8'h11);
        run(4'd5, 2'd1, 8'h00);            // 0x11-0xF0 -> 0x21, C=1
        run(4'd1, 2'd0, 8'h11);
        issue(4'd11, 2'd2, 8'h00);
        busy_cnt = 0;
        while (busy && busy_cnt < 50) begin
            busy_cnt++;
            @(negedge clk);
            if (busy_cnt == 5) check("mul_mid_leds", leds, 8'h11);
        end
        check("mul_busy_cycles", busy_cnt, 9);
        check("mul_leds", leds, 8'hFF);
        check("mul_c", flag_c, 0);
        check("mul_z", flag_z, 0);

        run(4'd1, 2'd0, 8'h10);
        run(4'd3, 2'd3, 8'h00);
        run(4'd11, 2'd3, 8'h00);
        check("mul2_leds", leds, 8'h00);
        check("mul2_z", flag_z, 1);
        check("mul2_c", flag_c, 1);

        // Back-to-back LDIs with valid held high
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = {4'd1, 2'd0, 8'(k + 1)};
            wait_ready("b2b_ready");
            acc_cyc[k] = cyc;
            if (k > 0) check("b2b_prev_leds", leds, k);
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        wait_ready("b2b_done");
        check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 2);
        check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 2);
        check("b2b_leds", leds, 8'h03);
        repeat (3) @(negedge clk);
        check("b2b_no_dup", leds, 8'h03);

        // Illegal opcode 13 with acc=0x33, C=1
        run(4'd1, 2'd0, 8'h67);
        run(4'd10, 2'd0, 8'h00);           // SHR -> 0x33, C=1
        check("shr_leds", leds, 8'h33);
        check("shr_c", flag_c, 1);
        issue(4'd13, 2'd0, 8'hAA);
        check("ill_exec", illegal, 0);
        @(negedge clk);
        check("ill_pulse", illegal, 1);
        check("ill_leds", leds, 8'h33);
        check("ill_z", flag_z, 0);
        check("ill_c", flag_c, 1);
        @(negedge clk);
        check("ill_pulse_end", illegal, 0);

        // Reset in 4th MUL cycle
        run(4'd1, 2'd0, 8'h05);
        run(4'd3, 2'd1, 8'h00);
        run(4'd1, 2'd0, 8'h03);
        issue(4'd11, 2'd1, 8'h00);
        repeat (4) @(negedge clk);
        check("mulrst_mid_leds", leds, 8'h03);
        rst = 1'b1;
        @(negedge clk);
        check("mulrst_ready_in_rst", instr_ready, 0);
        check("mulrst_leds", leds, 8'h00);
        check("mulrst_c", flag_c, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mulrst_ready_after", instr_ready, 1);
        run(4'd2, 2'd1, 8'h00);
        check("mulrst_ld_r1", leds, 8'h00);
        check("mulrst_ld_z", flag_z, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/semi_procesador_param.md
# semi_procesador_param

Parametrised multi-cycle accumulator processor, the next generation of the 64-series semi-processor top. It accepts one instruction at a time over a valid/ready handshake. It executes against an accumulator and a small register file, with an iterative shift-add multiplier. The accumulator is driven to `LEDS` for board observation. It sits directly below the board top, which maps switches and buttons onto the instruction port.

## Interface
- `W`, 8: data width of accumulator, registers, immediate, `LEDS`.
- `NREG`, 4: register-file depth, power of two, ≥ 2.
- `RA`, $clog2(NREG): register address width (derived, not overridden).
- `clk`  input  1  single clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `instr_valid`  input  1  instruction offered.
- `instr`  input  4+RA+W  {opcode[3:0], rd[RA-1:0], imm[W-1:0]}.
- `instr_ready`  output  1  block can accept; `state==IDLE && !rst`.
- `LEDS`  output  W  accumulator value (registered).
- `flag_z`  output  1  zero flag.
- `flag_c`  output  1  carry/borrow/overflow flag.
- `illegal`  output  1  one-cycle pulse on an undefined opcode.
- `busy`  output  1  `!instr_ready`.

## Operation
- FSM states: IDLE, EXEC, MUL.
  - IDLE: on `instr_valid && instr_ready`, register `instr`, go to EXEC.
  - EXEC: perform the op. MUL → MUL state; all other ops → IDLE.
  - MUL: run W iterations, then → IDLE.
- Opcodes. R = reg[rd]. All arithmetic is unsigned, mod 2^W.
  - 0 NOP: no change.
  - 1 LDI: acc=imm.
  - 2 LD: acc=R.
  - 3 ST: R=acc; flags unchanged.
  - 4 ADD: acc=acc+R; C=carry out.
  - 5 SUB: acc=acc−R; C=1 iff acc<R (borrow).
  - 6 AND, 7 OR, 8 XOR: acc=acc op R; C=0.
  - 9 SHL: acc=acc<<1; C=old acc[W-1].
  - 10 SHR: acc=acc>>1 (logical); C=old acc[0].
  - 11 MUL: 2W-bit product of acc×R; acc=low W bits; C=|high W bits.
  - 12–15: treated as NOP; `illegal` pulses for one cycle in EXEC; no state change.
- Z is set to (new acc==0) by every op that writes acc (1,2,4–11). It is unchanged by NOP, ST, and illegal opcodes.
- Multiplier: one shift-add step per MUL cycle, using a 2W-bit product register, a W-bit multiplicand copy, and a bit counter. Operands are sampled in EXEC. acc and R are not written until the final MUL cycle.
- Reset: acc=0, all registers=0, flag_z=0, flag_c=0, `illegal`=0, state=IDLE. `instr_ready`=0 while `rst`=1 and 1 in the first cycle after.
- Reset mid-EXEC or mid-MUL aborts the instruction. No partial result is written; the reset values above apply.
- `instr_valid` while busy is ignored; the source must hold the instruction until a ready handshake.

## Timing
- Handshake edge N (valid&ready sampled high) → EXEC during cycle N+1.
- Single-cycle ops: results (acc, R, flags, `LEDS`) update at edge N+1. `instr_ready`=1 in cycle N+2. Maximum throughput is one instruction per 2 cycles.
- MUL: MUL state occupies W cycles. Results update at edge N+1+W. `instr_ready` returns in cycle N+2+W.
- `illegal` is high in cycle N+2 only.
- ST followed by LD of the same register returns the stored value; there is no hazard, since ops are serialised.
- MUL with acc=0 or R=0 still takes the full W cycles. There is no early exit, so latency is fixed.

## Test plan
- Reset, then LDI 0x5A → `LEDS`=0x5A one edge after EXEC, Z=0, C=0. Assert `rst` mid-stream → `LEDS`=0, flags 0, registers read back 0.
- LDI 0xF0, ST r1, LDI 0x20, ADD r1 → `LEDS`=0x10, C=1, Z=0. Then SUB r1 → `LEDS`=0x20, C=1 (borrow), since 0x10<0xF0.
- LDI 0x0F, ST r2, LDI 0x11, MUL r2 → `busy` high for exactly 1+W=9 cycles. `LEDS`=0xFF, C=0. Then LDI 0x10, ST r3, MUL r3 (0x10×0x10) → `LEDS`=0x00, Z=1, C=1.
- Hold `instr_valid` high with back-to-back LDI 1, LDI 2, LDI 3 → each accepted every 2nd cycle. Final `LEDS`=0x03; no instruction dropped or duplicated.
- Opcode 13 with `LEDS`=0x33 → `illegal` is a one-cycle pulse; `LEDS`, Z, and C are unchanged.
- Assert `rst` during the 4th MUL cycle → no write to acc or R. `instr_ready`=1 the cycle after `rst` deasserts. A subsequent LD of the target register returns 0.
